// File: rtl/agu_arbiter.sv
// Load/store arbiter in front of a single shared AGU: picks one requester per
// cycle, tracks one in-flight op per requester and routes AGU results back by tag.
// Build option: define AGU_ARB_FIXED_PRIO_EN for fixed load-over-store priority
// instead of round-robin.

package uarch_pkg;
  localparam int XLEN      = 32;
  localparam int TAG_WIDTH = 5;
endpackage

package riscv_isa_pkg;
  import uarch_pkg::*;

  typedef struct packed {
    logic [XLEN-1:0]      pc;
    logic [XLEN-1:0]      imm;
    logic [4:0]           rs1;
    logic [TAG_WIDTH-1:0] dest_tag;
  } instruction_t;

  typedef struct packed {
    logic                 is_valid;
    logic [TAG_WIDTH-1:0] dest_tag;
    logic [XLEN-1:0]      result;
  } writeback_packet_t;
endpackage

module agu_arbiter
  import uarch_pkg::*;
  import riscv_isa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              cache_stall,
  input  logic              ld_agu_read_rdy,
  input  instruction_t      ld_agu_pkt,
  input  logic              st_agu_read_rdy,
  input  instruction_t      st_agu_pkt,
  output logic              agu_issue_valid,
  output instruction_t      agu_issue_pkt,
  output logic              agu_issue_src,
  input  logic              agu_issue_rdy,
  input  writeback_packet_t agu_result,
  output writeback_packet_t ld_agu_port,
  output writeback_packet_t st_agu_port,
  output logic              ld_grant,
  output logic              st_grant,
  output logic              stale_drop
);

  typedef enum logic {
    SRC_LD = 1'b0,
    SRC_ST = 1'b1
  } src_e;

  logic                 busy_ld_q, busy_ld_d;
  logic                 busy_st_q, busy_st_d;
  logic [TAG_WIDTH-1:0] tag_ld_q, tag_ld_d;
  logic [TAG_WIDTH-1:0] tag_st_q, tag_st_d;
  logic                 lock_q, lock_d;
  src_e                 lock_src_q, lock_src_d;
  logic                 ld_grant_q, ld_grant_d;
  logic                 st_grant_q, st_grant_d;
`ifndef AGU_ARB_FIXED_PRIO_EN
  src_e                 rr_ptr_q, rr_ptr_d;
`endif

  logic elig_ld, elig_st, lock_elig, active;
  logic issue_valid, accept, match_ld, match_st;
  src_e pref, sel;

  // Eligibility looks at the registered busy bit, so a result clearing busy
  // this cycle does not let the same requester reissue until the next cycle.
  assign active    = !rst && !flush;
  assign elig_ld   = ld_agu_read_rdy && !busy_ld_q;
  assign elig_st   = st_agu_read_rdy && !busy_st_q;
  assign lock_elig = (lock_src_q == SRC_LD) ? elig_ld : elig_st;

`ifdef AGU_ARB_FIXED_PRIO_EN
  assign pref = SRC_LD;
`else
  assign pref = rr_ptr_q;
`endif

  // NOTE: every variable assigned in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    sel = pref;
    if (lock_q && lock_elig) begin
      sel = lock_src_q;
    end else if (elig_ld && !elig_st) begin
      sel = SRC_LD;
    end else if (elig_st && !elig_ld) begin
      sel = SRC_ST;
    end
  end

  assign issue_valid = (elig_ld || elig_st) && !cache_stall && active;
  assign accept      = issue_valid && agu_issue_rdy;

  // Load wins when a result tag matches both in-flight ops.
  assign match_ld = active && agu_result.is_valid && busy_ld_q &&
                    (agu_result.dest_tag == tag_ld_q);
  assign match_st = active && agu_result.is_valid && busy_st_q &&
                    (agu_result.dest_tag == tag_st_q) && !match_ld;

  assign agu_issue_valid = issue_valid;
  assign agu_issue_src   = issue_valid && (sel == SRC_ST);
  assign agu_issue_pkt   = !issue_valid      ? '0 :
                           (sel == SRC_ST)   ? st_agu_pkt : ld_agu_pkt;
  assign ld_agu_port     = match_ld ? agu_result : '0;
  assign st_agu_port     = match_st ? agu_result : '0;
  assign stale_drop      = !rst && agu_result.is_valid && !match_ld && !match_st;
  assign ld_grant        = ld_grant_q && !rst;
  assign st_grant        = st_grant_q && !rst;

  always_comb begin
    busy_ld_d  = busy_ld_q;
    busy_st_d  = busy_st_q;
    tag_ld_d   = tag_ld_q;
    tag_st_d   = tag_st_q;
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    ld_grant_d = 1'b0;
    st_grant_d = 1'b0;
`ifndef AGU_ARB_FIXED_PRIO_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    if (flush) begin
      busy_ld_d  = 1'b0;
      busy_st_d  = 1'b0;
      tag_ld_d   = '0;
      tag_st_d   = '0;
      lock_d     = 1'b0;
      lock_src_d = SRC_LD;
`ifndef AGU_ARB_FIXED_PRIO_EN
      rr_ptr_d   = SRC_LD;
`endif
    end else begin
      if (match_ld) busy_ld_d = 1'b0;
      if (match_st) busy_st_d = 1'b0;
      if (accept) begin
        if (sel == SRC_LD) begin
          busy_ld_d  = 1'b1;
          tag_ld_d   = ld_agu_pkt.dest_tag;
          ld_grant_d = 1'b1;
        end else begin
          busy_st_d  = 1'b1;
          tag_st_d   = st_agu_pkt.dest_tag;
          st_grant_d = 1'b1;
        end
`ifndef AGU_ARB_FIXED_PRIO_EN
        rr_ptr_d = (sel == SRC_LD) ? SRC_ST : SRC_LD;
`endif
      end
      // An unaccepted offer pins the source; losing eligibility releases it.
      if (issue_valid) begin
        lock_d     = !agu_issue_rdy;
        lock_src_d = sel;
      end else if (lock_q && !lock_elig) begin
        lock_d = 1'b0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_ld_q  <= 1'b0;
      busy_st_q  <= 1'b0;
      tag_ld_q   <= '0;
      tag_st_q   <= '0;
      lock_q     <= 1'b0;
      lock_src_q <= SRC_LD;
      ld_grant_q <= 1'b0;
      st_grant_q <= 1'b0;
`ifndef AGU_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= SRC_LD;
`endif
    end else begin
      busy_ld_q  <= busy_ld_d;
      busy_st_q  <= busy_st_d;
      tag_ld_q   <= tag_ld_d;
      tag_st_q   <= tag_st_d;
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
      ld_grant_q <= ld_grant_d;
      st_grant_q <= st_grant_d;
`ifndef AGU_ARB_FIXED_PRIO_EN
      rr_ptr_q   <= rr_ptr_d;
`endif
    end
  end

endmodule
